dmem_mmio: RTL

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio.sv | 64 ++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM with a small MMIO block (DONE, CYCLE, SCRATCH, ID)
module dmem_mmio #(
  parameter int          RAM_WORDS  = 2048,
  parameter logic [31:0] DONE_VALUE = 32'hCAFEBABE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_code,
  output logic        addr_err
);
  localparam int          AW = $clog2(RAM_WORDS);
  localparam logic [31:0] ID = 32'h52563332;
  logic [31:0] mem [RAM_WORDS];
  logic [29:0] word;
  logic [AW-1:0] idx;
  logic        mmio_hit, ram_hit, unused_lsb;
  logic [31:0] cycle, scratch, done_q, rd_mux;
  assign word       = dmem_addr[31:2];
  assign idx        = word[AW-1:0];
  assign unused_lsb = ^dmem_addr[1:0];
  assign mmio_hit   = word[29:2] == 28'h200;
  assign ram_hit    = !mmio_hit && word < 30'(RAM_WORDS);
  // read mux: RAM, MMIO register selected by word[1:0], or 0 when unmapped
  always_comb
    rd_mux = ram_hit ? mem[idx] :
             !mmio_hit ? 32'd0 :
             word[1:0] == 2'd0 ? done_q :
             word[1:0] == 2'd1 ? cycle :
             word[1:0] == 2'd2 ? scratch : ID;
  // RAM array, deliberately not reset so test data survives a reset pulse
  always_ff @(posedge clk)
    if (dmem_we && ram_hit) mem[idx] <= dmem_wdata;
  // registered read data, MMIO registers and sticky end-of-test flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmem_rdata <= '0;
      cycle      <= '0;
      scratch    <= '0;
      done_q     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= '0;
      addr_err   <= 1'b0;
    end else begin
      dmem_rdata <= rd_mux;
      cycle      <= (dmem_we && mmio_hit && word[1:0] == 2'd1) ? dmem_wdata : cycle + 32'd1;
      if (dmem_we && mmio_hit && word[1:0] == 2'd2) scratch <= dmem_wdata;
      if (dmem_we && mmio_hit && word[1:0] == 2'd0) begin
        done_q <= dmem_wdata;
        if (!done) begin
          done      <= 1'b1;
          fail_code <= dmem_wdata;
          pass      <= dmem_wdata == DONE_VALUE;
        end
      end
      if (!ram_hit && !mmio_hit) addr_err <= 1'b1;
    end
endmodule
